// File: rtl/dcache_sram_nway_if.sv
// Request, lookup and write-back signal bundle for the N-way data-cache tag/data store.
// The cache drives the slave side; the data-cache controller drives the master side.
interface dcache_sram_nway_if #(
  parameter int SETS   = 16,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256
);
  localparam int IDX_W = $clog2(SETS);

  logic              enable_i;
  logic              write_i;
  logic [IDX_W-1:0]  addr_i;
  logic [TAG_W+1:0]  tag_i;
  logic [LINE_W-1:0] data_i;
  logic [TAG_W+1:0]  tag_o;
  logic [LINE_W-1:0] data_o;
  logic              hit_o;
  logic              flush_req_i;
  logic              flush_busy_o;
  logic              flush_done_o;
  logic              wb_valid_o;
  logic              wb_ready_i;
  logic [IDX_W-1:0]  wb_idx_o;
  logic [TAG_W-1:0]  wb_tag_o;
  logic [LINE_W-1:0] wb_data_o;

  modport slave (
    input  enable_i, write_i, addr_i, tag_i, data_i, flush_req_i, wb_ready_i,
    output tag_o, data_o, hit_o, flush_busy_o, flush_done_o,
           wb_valid_o, wb_idx_o, wb_tag_o, wb_data_o
  );

  modport master (
    output enable_i, write_i, addr_i, tag_i, data_i, flush_req_i, wb_ready_i,
    input  tag_o, data_o, hit_o, flush_busy_o, flush_done_o,
           wb_valid_o, wb_idx_o, wb_tag_o, wb_data_o
  );
endinterface

// File: rtl/dcache_sram_nway.sv
// N-way set-associative data-cache tag/data store with true-LRU victim choice and a dirty-line flush engine.
// Define DCACHE_FLUSH_INVALIDATE_EN to make a flush also invalidate every entry and reset the LRU order.
module dcache_sram_nway #(
  parameter int WAYS   = 4,
  parameter int SETS   = 16,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256
) (
  input logic                clk_i,
  input logic                rst_i,
  dcache_sram_nway_if.slave  bus
);
  localparam int AGE_W = $clog2(WAYS);
  localparam int IDX_W = $clog2(SETS);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  logic              r_valid [SETS][WAYS];
  logic              r_dirty [SETS][WAYS];
  logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
  logic [LINE_W-1:0] r_data  [SETS][WAYS];
  logic [AGE_W-1:0]  r_age   [SETS][WAYS];

  state_t            r_state;
  logic [IDX_W-1:0]  r_ptrSet;
  logic [AGE_W-1:0]  r_ptrWay;
  logic              r_busy;
  logic              r_done;
  logic              r_wbValid;
  logic [IDX_W-1:0]  r_wbIdx;
  logic [TAG_W-1:0]  r_wbTag;
  logic [LINE_W-1:0] r_wbData;

  logic [IDX_W-1:0]  w_set;
  logic              w_hit;
  logic [AGE_W-1:0]  w_hitWay;
  logic              w_anyInv;
  logic [AGE_W-1:0]  w_invWay;
  logic [AGE_W-1:0]  w_lruWay;
  logic [AGE_W-1:0]  w_selWay;
  logic [AGE_W-1:0]  w_selAge;
  logic              w_update;
  logic              w_lastEntry;

  assign w_set = bus.addr_i;

  // Descending scan so the lowest-index invalid or hitting way wins.
  always_comb begin
    w_hit    = 1'b0;
    w_hitWay = '0;
    w_anyInv = 1'b0;
    w_invWay = '0;
    w_lruWay = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_set][w]) begin
        w_anyInv = 1'b1;
        w_invWay = AGE_W'(w);
      end
      if (r_age[w_set][w] == AGE_W'(WAYS - 1)) begin
        w_lruWay = AGE_W'(w);
      end
      if (r_valid[w_set][w] && (r_tag[w_set][w] == bus.tag_i[TAG_W-1:0])) begin
        w_hit    = 1'b1;
        w_hitWay = AGE_W'(w);
      end
    end
    w_selWay = w_hit ? w_hitWay : (w_anyInv ? w_invWay : w_lruWay);
  end

  assign w_selAge    = r_age[w_set][w_selWay];
  assign w_update    = bus.enable_i && !r_busy && (w_hit || bus.write_i);
  assign w_lastEntry = (r_ptrSet == IDX_W'(SETS - 1)) && (r_ptrWay == AGE_W'(WAYS - 1));

  assign bus.hit_o  = r_busy ? 1'b0 : (bus.enable_i ? w_hit : 1'b1);
  assign bus.tag_o  = bus.enable_i ? {r_valid[w_set][w_selWay], r_dirty[w_set][w_selWay],
                                      r_tag[w_set][w_selWay]} : '0;
  assign bus.data_o = bus.enable_i ? r_data[w_set][w_selWay] : '0;

  assign bus.flush_busy_o = r_busy;
  assign bus.flush_done_o = r_done;
  assign bus.wb_valid_o   = r_wbValid;
  assign bus.wb_idx_o     = r_wbIdx;
  assign bus.wb_tag_o     = r_wbTag;
  assign bus.wb_data_o    = r_wbData;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
          r_tag[s][w]   <= '0;
          r_data[s][w]  <= '0;
          r_age[s][w]   <= AGE_W'(w);
        end
      end
      r_state   <= IDLE;
      r_ptrSet  <= '0;
      r_ptrWay  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wbValid <= 1'b0;
      r_wbIdx   <= '0;
      r_wbTag   <= '0;
      r_wbData  <= '0;
    end else begin
      // Accesses are only accepted while the flush engine is not walking the arrays.
      if (w_update) begin
        for (int w = 0; w < WAYS; w++) begin
          if (r_age[w_set][w] < w_selAge) begin
            r_age[w_set][w] <= r_age[w_set][w] + AGE_W'(1);
          end
        end
        r_age[w_set][w_selWay] <= '0;
        if (bus.write_i) begin
          r_data[w_set][w_selWay] <= bus.data_i;
          if (w_hit) begin
            r_dirty[w_set][w_selWay] <= 1'b1;
          end else begin
            r_valid[w_set][w_selWay] <= bus.tag_i[TAG_W+1];
            r_dirty[w_set][w_selWay] <= bus.tag_i[TAG_W];
            r_tag[w_set][w_selWay]   <= bus.tag_i[TAG_W-1:0];
          end
        end
      end

      case (r_state)
        IDLE: begin
          if (bus.flush_req_i) begin
            r_state  <= SCAN;
            r_ptrSet <= '0;
            r_ptrWay <= '0;
            r_busy   <= 1'b1;
          end
        end
        SCAN: begin
          if (r_valid[r_ptrSet][r_ptrWay] && r_dirty[r_ptrSet][r_ptrWay]) begin
            r_state   <= EMIT;
            r_wbValid <= 1'b1;
            r_wbIdx   <= r_ptrSet;
            r_wbTag   <= r_tag[r_ptrSet][r_ptrWay];
            r_wbData  <= r_data[r_ptrSet][r_ptrWay];
          end else begin
`ifdef DCACHE_FLUSH_INVALIDATE_EN
            r_valid[r_ptrSet][r_ptrWay] <= 1'b0;
`endif
            if (w_lastEntry) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
`ifdef DCACHE_FLUSH_INVALIDATE_EN
              for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                  r_age[s][w] <= AGE_W'(w);
                end
              end
`endif
            end else begin
              r_ptrWay <= r_ptrWay + AGE_W'(1);
              if (r_ptrWay == AGE_W'(WAYS - 1)) begin
                r_ptrSet <= r_ptrSet + IDX_W'(1);
              end
            end
          end
        end
        EMIT: begin
          if (bus.wb_ready_i) begin
            r_wbValid                   <= 1'b0;
            r_dirty[r_ptrSet][r_ptrWay] <= 1'b0;
`ifdef DCACHE_FLUSH_INVALIDATE_EN
            r_valid[r_ptrSet][r_ptrWay] <= 1'b0;
`endif
            if (w_lastEntry) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
`ifdef DCACHE_FLUSH_INVALIDATE_EN
              for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                  r_age[s][w] <= AGE_W'(w);
                end
              end
`endif
            end else begin
              r_state  <= SCAN;
              r_ptrWay <= r_ptrWay + AGE_W'(1);
              if (r_ptrWay == AGE_W'(WAYS - 1)) begin
                r_ptrSet <= r_ptrSet + IDX_W'(1);
              end
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
